fpu_flag_ctrl: RTL
==================

FPU_FLAG_CTRL -- requirements
Module: fpu_flag_ctrl

Interface
REQ-001 Parameters, one per line: EXP, 8, exponent width; MANTISSA, 23, fraction width; FLEN, 32, result width (= 1+EXP+MANTISSA).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 res_valid  in  1  FPU result offered.
REQ-005 res_ready  out  1  controller accepts result; a transfer occurs when res_valid && res_ready.
REQ-006 res_data  in  FLEN  FPU result, packed {sign, exp, mantissa}.
REQ-007 res_dz  in  1  datapath reports divide-by-zero.
REQ-008 res_nx  in  1  datapath reports rounding loss (inexact).
REQ-009 res_inf_op  in  1  an operand was already infinite.
REQ-010 csr_we  in  1  fflags write strobe.
REQ-011 csr_wdata  in  5  fflags write value.
REQ-012 csr_rdata  out  5  current fflags {NV,DZ,OF,UF,NX}.
REQ-013 flag_valid  out  1  one-cycle pulse: per-op flags below are valid.
REQ-014 op_flags  out  5  flags of the retired op, same bit order.
REQ-015 exc_nan, exc_pinf, exc_ninf  out  1 each  classification of the retired op.
REQ-016 trap_mask  in  5  per-flag trap enable.
REQ-017 trap_req  out  1  trap request to core.
REQ-018 trap_ack  in  1  core accepted trap.

Function
REQ-019 Classification: NaN = exp all-ones and mantissa non-zero; pinf/ninf = exp all-ones, mantissa zero, sign 0/1; only one asserted at a time.
REQ-020 Flag derivation: NV = NaN; DZ = res_dz; OF = (pinf|ninf) && !res_dz && !res_inf_op; UF = exp zero && mantissa non-zero && res_nx; NX = res_nx | OF.
REQ-021 Stage 1: on transfer, register res_data and sideband (s1_valid=1); otherwise s1_valid=0.
REQ-022 Stage 2: when s1_valid, the next edge drives flag_valid=1, op_flags and exc_* from stage-1 contents, and ORs op_flags into fflags; csr_rdata reflects the update two cycles after the transfer.
REQ-023 flag_valid, op_flags and exc_* are zero in any cycle without a retiring op.
REQ-024 fflags bits are sticky; only rst or csr_we clears them.
REQ-025 csr_we alone: fflags <= csr_wdata next edge.
REQ-026 csr_we coincident with a stage-2 update: fflags <= csr_wdata | op_flags (the op's flags are never lost).
REQ-027 Without trap stall, throughput is one result per cycle; res_ready = 1.
REQ-028 Trap FSM states IDLE, PEND; IDLE->PEND when the stage-2 update has (op_flags & trap_mask) != 0; PEND->IDLE on trap_ack; trap_req = (state == PEND).
REQ-029 res_ready = 0 while state == PEND, or while s1_valid && (stage-1 derived flags & trap_mask) != 0; no result is accepted after a trapping op until trap_ack.
REQ-030 trap_ack in IDLE is ignored; trap_mask changes take effect on the next stage-2 update.

Reset
REQ-031 On rst: fflags = 0, s1_valid = 0, state = IDLE, flag_valid = 0, op_flags = 0, exc_* = 0, trap_req = 0; res_ready = 1 in the first cycle after reset.
REQ-032 rst mid-operation discards any stage-1 op and any pending trap; rst overrides csr_we.

Configuration
REQ-033 Macro FPU_FLAG_TRAP_EN: when defined, the trap FSM, trap_req and the REQ-029 stall are implemented.
REQ-034 When not defined: trap_req is constant 0, res_ready is constant 1, trap_mask and trap_ack are ignored, and the ports remain present.

Verification
REQ-035 Input 0x7FC00000, res_nx=0 -> two cycles later flag_valid=1, op_flags=5'b10000, exc_nan=1, csr_rdata=5'b10000.
REQ-036 Input 0x7F800000, res_dz=0, res_inf_op=0 -> op_flags=5'b00101, exc_pinf=1; then input 0xFF800000 with res_dz=1 -> op_flags=5'b01000, exc_ninf=1, csr_rdata=5'b01101.
REQ-037 Input 0x00000001 with res_nx=1 -> op_flags=5'b00011; csr_we=1, csr_wdata=0 on the same edge as the update -> csr_rdata=5'b00011.
REQ-038 (FPU_FLAG_TRAP_EN) trap_mask=5'b10000, input NaN followed by a valid normal number -> res_ready drops the cycle after the NaN transfer, trap_req=1, second result held; trap_ack -> IDLE, second result accepted.
REQ-039 Back-to-back valid inputs 0x3F800000 with res_nx alternating 1/0 for 4 cycles -> flag_valid high for 4 consecutive cycles, op_flags alternating 5'b00001 and 0, csr_rdata=5'b00001.
REQ-040 rst asserted with s1_valid=1 and state=PEND -> next cycle all outputs zero, res_ready=1, csr_rdata=0.

Source files
------------

// File: rtl/fpu_flag_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_flag_ctrl
// Retires FPU results, classifies them (NaN / +inf / -inf), derives the IEEE
// exception flags {NV,DZ,OF,UF,NX}, accumulates them into the sticky fflags
// CSR and optionally raises a trap for flags that are enabled in trap_mask.
//
// Optional feature macro: FPU_FLAG_TRAP_EN
//   defined   : trap FSM (IDLE/PEND), trap_req and input stall are built.
//   undefined : trap_req = 0, res_ready = 1, trap_mask/trap_ack ignored.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   res_valid/res_ready       result handshake (transfer = valid && ready)
//   res_data                  FPU result {sign, exp, mantissa}
//   res_dz/res_nx/res_inf_op  datapath sideband for the offered result
//   csr_we/csr_wdata          fflags write port
//   csr_rdata                 current fflags
//   flag_valid                one-cycle pulse per retired op
//   op_flags, exc_*           flags/classification of the retired op
//   trap_mask                 per-flag trap enable
//   trap_req/trap_ack         trap handshake with the core
//
// Pipeline: transfer -> stage 1 (register) -> stage 2 (flags out, fflags).
// ---------------------------------------------------------------------------
module fpu_flag_ctrl #(
  parameter int unsigned EXP      = 8,
  parameter int unsigned MANTISSA = 23,
  parameter int unsigned FLEN     = 1 + EXP + MANTISSA
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [FLEN-1:0] res_data,
  input  logic            res_dz,
  input  logic            res_nx,
  input  logic            res_inf_op,
  input  logic            csr_we,
  input  logic [4:0]      csr_wdata,
  output logic [4:0]      csr_rdata,
  output logic            flag_valid,
  output logic [4:0]      op_flags,
  output logic            exc_nan,
  output logic            exc_pinf,
  output logic            exc_ninf,
  input  logic [4:0]      trap_mask,
  output logic            trap_req,
  input  logic            trap_ack
);

  localparam int unsigned NFLAGS   = 5;
  localparam int unsigned SIGN_BIT = EXP + MANTISSA;

  // Stage-1 holding registers
  logic                s1_valid;
  logic [FLEN-1:0]     s1_data;
  logic                s1_dz;
  logic                s1_nx;
  logic                s1_inf_op;

  // Stage-1 decode
  logic                s1_sign;
  logic [EXP-1:0]      s1_exp;
  logic [MANTISSA-1:0] s1_man;
  logic                exp_ones;
  logic                exp_zero;
  logic                man_zero;
  logic                s1_nan;
  logic                s1_pinf;
  logic                s1_ninf;
  logic                s1_of;
  logic [NFLAGS-1:0]   s1_flags;
  logic [NFLAGS-1:0]   upd_flags;

  logic                xfer;
  logic [NFLAGS-1:0]   fflags;

  assign xfer      = res_valid & res_ready;
  assign csr_rdata = fflags;

  // Stage 1: capture the accepted result and its sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_dz     <= 1'b0;
      s1_nx     <= 1'b0;
      s1_inf_op <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_data   <= res_data;
        s1_dz     <= res_dz;
        s1_nx     <= res_nx;
        s1_inf_op <= res_inf_op;
      end
    end
  end

  // Classification and flag derivation from stage-1 contents
  always_comb begin
    s1_sign  = s1_data[SIGN_BIT];
    s1_exp   = s1_data[MANTISSA +: EXP];
    s1_man   = s1_data[MANTISSA-1:0];
    exp_ones = &s1_exp;
    exp_zero = ~|s1_exp;
    man_zero = ~|s1_man;
    s1_nan   = exp_ones & ~man_zero;
    s1_pinf  = exp_ones &  man_zero & ~s1_sign;
    s1_ninf  = exp_ones &  man_zero &  s1_sign;
    // Overflow only when the infinity was produced here, not propagated or DZ
    s1_of    = (s1_pinf | s1_ninf) & ~s1_dz & ~s1_inf_op;
    s1_flags = {s1_nan, s1_dz, s1_of, exp_zero & ~man_zero & s1_nx, s1_nx | s1_of};
  end

  assign upd_flags = s1_valid ? s1_flags : '0;

  // Stage 2: per-op outputs, zero in cycles without a retiring op
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_valid <= 1'b0;
      op_flags   <= '0;
      exc_nan    <= 1'b0;
      exc_pinf   <= 1'b0;
      exc_ninf   <= 1'b0;
    end else begin
      flag_valid <= s1_valid;
      op_flags   <= upd_flags;
      exc_nan    <= s1_valid & s1_nan;
      exc_pinf   <= s1_valid & s1_pinf;
      exc_ninf   <= s1_valid & s1_ninf;
    end
  end

  // Sticky fflags; a CSR write merges with a coincident retiring op
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else if (csr_we) begin
      fflags <= csr_wdata | upd_flags;
    end else begin
      fflags <= fflags | upd_flags;
    end
  end

`ifdef FPU_FLAG_TRAP_EN
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   s1_trap;

  // Stage-1 op will trap at its stage-2 update
  assign s1_trap = s1_valid & (|(s1_flags & trap_mask));

  // Trap state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Trap next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s1_trap)  state_nxt = PEND;
      PEND:    if (trap_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trap outputs; stall already while the trapping op sits in stage 1
  always_comb begin
    trap_req  = 1'b0;
    res_ready = 1'b1;
    if (state == PEND) begin
      trap_req  = 1'b1;
      res_ready = 1'b0;
    end
    if (s1_trap) begin
      res_ready = 1'b0;
    end
  end
`else
  logic unused_trap_inputs;

  assign trap_req           = 1'b0;
  assign res_ready          = 1'b1;
  assign unused_trap_inputs = ^{trap_mask, trap_ack};
`endif

endmodule
